// File: rtl/bus_ctrl_pkg.sv
// Shared constants for the CPU-side bus controller: active-low strobe levels,
// access direction and the 2-bit FSM state encodings.
package bus_ctrl_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

endpackage

// File: rtl/bus_ctrl_timeout_cnt.sv
// Saturating cycle counter with synchronous clear, used to bound the
// number of cycles an external access may spend waiting for ready.
module bus_timeout_cnt
  import bus_ctrl_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int SAT_VAL = 255,
  parameter int EXP_VAL = 254
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(SAT_VAL);
  localparam logic [CNT_W-1:0] EXP = CNT_W'(EXP_VAL);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != SAT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt >= EXP);

endmodule

// File: rtl/bus_ctrl.sv
// CPU-side bus controller: zero-wait scratch-pad hits are served combinationally,
// misses go through a request/grant/ready external bus access with timeout.
module bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int SPM_HI_W = 18,
  parameter int SPM_BASE = 0,
  parameter int TIMEOUT  = 255,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic              as_,
  input  logic              rw,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              bus_err,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  output logic [BE_W-1:0]   spm_be,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  output logic [BE_W-1:0]   bus_be,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [SPM_HI_W-1:0] SPM_TAG = SPM_HI_W'(SPM_BASE);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic [DATA_W-1:0] r_wr_data;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_rd_buf;
  logic              r_discard;

  logic [1:0]        w_next_state;
  logic              w_hit;
  logic              w_latch;
  logic              w_cap;
  logic              w_discard;
  logic              w_expired;
  logic [DATA_W-1:0] w_bus_rd;

  assign spm_addr    = addr;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;
  assign spm_be      = be;

  assign bus_addr    = r_addr;
  assign bus_rw      = r_rw;
  assign bus_wr_data = r_wr_data;
  assign bus_be      = r_be;

  assign w_hit     = (addr[ADDR_W-1 -: SPM_HI_W] == SPM_TAG);
  assign w_discard = r_discard | flush;
  // Writes return no data, so they never expose whatever the bus drives back.
  assign w_bus_rd  = (r_rw == READ) ? bus_rd_data : '0;

  bus_timeout_cnt #(
    .CNT_W  (CNT_W),
    .SAT_VAL(TIMEOUT),
    .EXP_VAL(TIMEOUT - 1)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (r_state != ST_ACCESS),
    .i_en     (r_state == ST_ACCESS),
    .o_expired(w_expired)
  );

  always_comb begin
    w_next_state = r_state;
    rd_data      = '0;
    busy         = 1'b0;
    bus_err      = 1'b0;
    spm_as_      = DISABLE_;
    bus_req_     = DISABLE_;
    bus_as_      = DISABLE_;
    w_latch      = 1'b0;
    w_cap        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((as_ == ENABLE_) && !flush) begin
          if (w_hit) begin
            if (!stall) begin
              spm_as_ = ENABLE_;
              rd_data = spm_rd_data;
            end
          end else begin
            busy         = 1'b1;
            w_latch      = 1'b1;
            w_next_state = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        bus_req_ = ENABLE_;
        busy     = 1'b1;
        if (flush) begin
          w_next_state = ST_IDLE;
        end else if (bus_grnt_ == ENABLE_) begin
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        bus_req_ = ENABLE_;
        bus_as_  = ENABLE_;
        // Ready takes priority over a timeout expiring in the same cycle.
        if (bus_rdy_ == ENABLE_) begin
          if (w_discard) begin
            busy         = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_cap        = 1'b1;
            rd_data      = w_bus_rd;
            w_next_state = stall ? ST_WAIT : ST_IDLE;
          end
        end else if (w_expired) begin
          bus_err      = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      ST_WAIT: begin
        rd_data = r_rd_buf;
        if (!stall) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_rw      <= 1'b0;
      r_wr_data <= '0;
      r_be      <= '0;
      r_rd_buf  <= '0;
      r_discard <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_latch) begin
        r_addr    <= addr;
        r_rw      <= rw;
        r_wr_data <= wr_data;
        r_be      <= be;
      end
      if (w_cap) begin
        r_rd_buf <= w_bus_rd;
      end
      // Discard is remembered only while the access stays outstanding.
      r_discard <= (r_state == ST_ACCESS) && (w_next_state == ST_ACCESS) && w_discard;
    end
  end

  a_grant_held: assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_ACCESS) |-> (bus_grnt_ == ENABLE_));

endmodule
